// File: rtl/irq_controller.sv
// Interrupt initiator: edge-detects request lines, masks and prioritises them, and
// holds one trap outstanding until retE. Build option IRQ_SYNC_EN adds a 2-flop input synchronizer.
module irq_controller #(
    parameter int                 NUM_IRQ    = 8,
    parameter int                 CAUSE_W    = 3,
    parameter logic [NUM_IRQ-1:0] MASK_RESET = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               irq_en,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               retE,
    output logic               interrupt,
    output logic [CAUSE_W-1:0] cause,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic               spurious_ret
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FIRE    = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] candidates;
    logic [NUM_IRQ-1:0] clr;
    logic               any_cand;
    logic [CAUSE_W-1:0] winner;
    logic [1:0]         state_q, state_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               spur_q, spur_d;
    logic               interrupt_q, in_service_q;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    assign rise       = irq_s & ~irq_prev_q;
    assign candidates = pending_q & mask_q;
    assign any_cand   = |candidates;

    // Scan from the top so the lowest set index is the last assignment and wins.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (candidates[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        spur_d  = spur_q;
        clr     = '0;
        case (state_q)
            ST_IDLE: begin
                if (retE) begin
                    spur_d = 1'b1;
                end
                if (irq_en && any_cand) begin
                    state_d = ST_FIRE;
                    cause_d = winner;
                    clr     = NUM_IRQ'(1) << winner;
                end
            end
            ST_FIRE:    state_d = ST_SERVICE;
            ST_SERVICE: begin
                if (retE) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // A fresh edge on the bit being serviced re-arms it: set takes precedence over clear.
    assign pending_d = (pending_q & ~clr) | rise;
    assign mask_d    = mask_we ? mask_wdata : mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q   <= '0;
            pending_q    <= '0;
            mask_q       <= MASK_RESET;
            state_q      <= ST_IDLE;
            cause_q      <= '0;
            spur_q       <= 1'b0;
            interrupt_q  <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            irq_prev_q   <= irq_s;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            state_q      <= state_d;
            cause_q      <= cause_d;
            spur_q       <= spur_d;
            interrupt_q  <= (state_d == ST_FIRE);
            in_service_q <= (state_d != ST_IDLE);
        end
    end

    assign interrupt    = interrupt_q;
    assign in_service   = in_service_q;
    assign cause        = cause_q;
    assign pending      = pending_q;
    assign spurious_ret = spur_q;

endmodule
